// File: rtl/div_pkg.sv
// Shared constants, FSM state type and sign helper for the radix-2 divider.
package div_pkg;

  localparam int unsigned DIV_W = 16;
  localparam int unsigned STEPS = 16;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [DIV_W-1:0] cond_neg(input logic [DIV_W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/restore_sub17.sv
// 17-bit ripple subtractor (a - b) built from full-adder cells; borrow=1 means a < b.
module restore_sub17 (
  input  logic [16:0] i_a,
  input  logic [16:0] i_b,
  output logic [16:0] o_diff,
  output logic        o_borrow
);

  logic [17:0] w_c;
  logic [16:0] w_bn;

  assign w_c[0] = 1'b1;
  assign w_bn   = ~i_b;

  for (genvar i = 0; i < 17; i++) begin : g_fa
    assign o_diff[i]  = i_a[i] ^ w_bn[i] ^ w_c[i];
    assign w_c[i + 1] = (i_a[i] & w_bn[i]) | (w_c[i] & (i_a[i] ^ w_bn[i]));
  end

  assign o_borrow = ~w_c[17];

endmodule

// File: rtl/radix2_div16_16.sv
// Sequential radix-2 restoring divider, signed/unsigned, 16 steps plus one DONE cycle.
module radix2_div16_16 #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic             div_by_zero,
  output logic             ovf
);

  div_pkg::state_t               r_state;
  logic [div_pkg::CNT_W-1:0]     r_cnt;
  logic [DIV_W:0]                r_rem;
  logic [DIV_W-1:0]              r_quo;
  logic [DIV_W-1:0]              r_dvs;
  logic                          r_neg_q;
  logic                          r_neg_r;
  logic                          r_dz;
  logic                          r_ovf;

  logic                          w_a_neg;
  logic                          w_b_neg;
  logic [DIV_W-1:0]              w_a_mag;
  logic [DIV_W-1:0]              w_b_mag;
  logic [DIV_W:0]                w_shift;
  logic [DIV_W:0]                w_diff;
  logic                          w_borrow;
  logic [DIV_W:0]                w_rem_nxt;
  logic [DIV_W-1:0]              w_quo_nxt;
  logic [DIV_W-1:0]              w_q_fin;
  logic [DIV_W-1:0]              w_r_fin;
  logic                          w_unused_rem_msb;

  assign w_a_neg = signed_mode & dividend[DIV_W-1];
  assign w_b_neg = signed_mode & divisor[DIV_W-1];
  assign w_a_mag = div_pkg::cond_neg(dividend, w_a_neg);
  assign w_b_mag = div_pkg::cond_neg(divisor, w_b_neg);

  // Dividend magnitude lives in r_quo and is shifted out MSB-first as quotient bits shift in.
  assign w_shift = {r_rem[DIV_W-1:0], r_quo[DIV_W-1]};

  restore_sub17 u_sub (
    .i_a      (w_shift),
    .i_b      ({1'b0, r_dvs}),
    .o_diff   (w_diff),
    .o_borrow (w_borrow)
  );

  assign w_rem_nxt = w_borrow ? w_shift : w_diff;
  assign w_quo_nxt = {r_quo[DIV_W-2:0], ~w_borrow};

  // The partial remainder stays below the divisor, so its top bit is never carried forward.
  assign w_unused_rem_msb = r_rem[DIV_W];

  assign w_q_fin = r_dz ? '1 : div_pkg::cond_neg(w_quo_nxt, r_neg_q);
  assign w_r_fin = div_pkg::cond_neg(w_rem_nxt[DIV_W-1:0], r_neg_r);

  assign busy = (r_state != div_pkg::S_IDLE);
  assign done = (r_state == div_pkg::S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= div_pkg::S_IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dz        <= 1'b0;
      r_ovf       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      case (r_state)
        div_pkg::S_IDLE: begin
          if (start) begin
            r_rem   <= '0;
            r_quo   <= w_a_mag;
            r_dvs   <= w_b_mag;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_dz    <= (divisor == '0);
            r_ovf   <= signed_mode && (dividend == {1'b1, {(DIV_W-1){1'b0}}})
                       && (divisor == '1);
            r_cnt   <= '0;
            r_state <= div_pkg::S_CALC;
          end
        end
        div_pkg::S_CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          if (r_cnt == div_pkg::LAST_STEP) begin
            r_cnt       <= '0;
            quotient    <= w_q_fin;
            remainder   <= w_r_fin;
            div_by_zero <= r_dz;
            ovf         <= r_ovf;
            r_state     <= div_pkg::S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        div_pkg::S_DONE: r_state <= div_pkg::S_IDLE;
        default:         r_state <= div_pkg::S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_radix2_div16_16.sv
// Self-checking bench: arithmetic reference model plus directed literal vectors.
module tb_radix2_div16_16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        signed_mode;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  radix2_div16_16 #(.DIV_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .ovf         (ovf)
  );

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        ov;
  } res_t;

  function automatic res_t ref_div(input logic sm, input logic [15:0] a, input logic [15:0] b);
    res_t res;
    int   sa;
    int   sb;
    res = '0;
    if (b == 16'd0) begin
      res.q  = 16'hFFFF;
      res.r  = a;
      res.dz = 1'b1;
    end else if (!sm) begin
      res.q = a / b;
      res.r = a % b;
    end else begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sa == -32768 && sb == -1) begin
        res.q  = 16'h8000;
        res.r  = 16'h0000;
        res.ov = 1'b1;
      end else begin
        res.q = 16'(sa / sb);
        res.r = 16'(sa % sb);
      end
    end
    return res;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: m_cnt counts edges since acceptance; results appear 16 edges later for one cycle.
  int   m_cnt;
  res_t m_pend;
  res_t m_out;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_pend <= '0;
      m_out  <= '0;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_pend <= ref_div(signed_mode, dividend, divisor);
        m_cnt  <= 1;
      end
    end else if (m_cnt == 16) begin
      m_out <= m_pend;
      m_cnt <= 17;
    end else if (m_cnt == 17) begin
      m_cnt <= 0;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("busy", {31'd0, busy}, {31'd0, m_cnt != 0});
      chk("done", {31'd0, done}, {31'd0, m_cnt == 17});
      chk("quotient", {16'd0, quotient}, {16'd0, m_out.q});
      chk("remainder", {16'd0, remainder}, {16'd0, m_out.r});
      chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, m_out.dz});
      chk("ovf", {31'd0, ovf}, {31'd0, m_out.ov});
    end
  end

  task automatic do_op(input logic sm, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er,
                       input logic edz, input logic eov, input bit lit);
    int k;
    bit seen;
    @(negedge clk);
    signed_mode = sm;
    dividend    = a;
    divisor     = b;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    dividend    = 16'($urandom);
    divisor     = 16'($urandom);
    signed_mode = 1'($urandom);
    seen = 1'b0;
    k    = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (done) seen = 1'b1;
    end
    chk("latency", k, 16);
    if (lit) begin
      chk("lit_quotient", {16'd0, quotient}, {16'd0, eq});
      chk("lit_remainder", {16'd0, remainder}, {16'd0, er});
      chk("lit_div_by_zero", {31'd0, div_by_zero}, {31'd0, edz});
      chk("lit_ovf", {31'd0, ovf}, {31'd0, eov});
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quotient", {16'd0, quotient}, 32'd0);
    chk("rst_remainder", {16'd0, remainder}, 32'd0);
    chk("rst_div_by_zero", {31'd0, div_by_zero}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n_done;
    logic [15:0] q_seen;
    logic [15:0] r_seen;
    logic        sm;
    logic [15:0] a;
    logic [15:0] b;

    rst_n       = 1'b0;
    start       = 1'b0;
    signed_mode = 1'b0;
    dividend    = '0;
    divisor     = '0;
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;

    do_op(1'b0, 16'd100,   16'd7,     16'd14,    16'd2,     1'b0, 1'b0, 1'b1);
    do_op(1'b1, 16'hFF9C,  16'd7,     16'hFFF2,  16'hFFFE,  1'b0, 1'b0, 1'b1);
    do_op(1'b0, 16'hFFFF,  16'd1,     16'hFFFF,  16'd0,     1'b0, 1'b0, 1'b1);
    do_op(1'b0, 16'd1234,  16'd0,     16'hFFFF,  16'd1234,  1'b1, 1'b0, 1'b1);
    do_op(1'b1, 16'h8000,  16'hFFFF,  16'h8000,  16'd0,     1'b0, 1'b1, 1'b1);
    do_op(1'b1, 16'd100,   16'hFFF9,  16'hFFF2,  16'd2,     1'b0, 1'b0, 1'b1);
    do_op(1'b1, 16'hFF9C,  16'hFFF9,  16'd14,    16'hFFFE,  1'b0, 1'b0, 1'b1);
    do_op(1'b1, 16'hFF9C,  16'd0,     16'hFFFF,  16'hFF9C,  1'b1, 1'b0, 1'b1);
    do_op(1'b0, 16'h8000,  16'hFFFF,  16'd0,     16'h8000,  1'b0, 1'b0, 1'b1);
    do_op(1'b0, 16'd5,     16'd9,     16'd0,     16'd5,     1'b0, 1'b0, 1'b1);

    // A second start mid-operation must be ignored entirely.
    @(negedge clk);
    signed_mode = 1'b0;
    dividend    = 16'd50;
    divisor     = 16'd5;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    dividend = 16'd9;
    divisor  = 16'd3;
    start    = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    n_done = 0;
    q_seen = '0;
    r_seen = '0;
    for (int k = 6; k <= 25; k++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        q_seen = quotient;
        r_seen = remainder;
      end
    end
    chk("busy_start_dones", n_done, 1);
    chk("busy_start_quotient", {16'd0, q_seen}, 32'd10);
    chk("busy_start_remainder", {16'd0, r_seen}, 32'd0);

    // Reset in the middle of CALC.
    @(negedge clk);
    dividend = 16'd50;
    divisor  = 16'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs();
    @(negedge clk);
    rst_n  = 1'b1;
    n_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("abort_no_done", n_done, 0);
    do_op(1'b0, 16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 2000; i++) begin
      sm = 1'($urandom);
      a  = 16'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      if ($urandom_range(0, 7) == 0) b = 16'($urandom_range(0, 16)) - 16'd8;
      do_op(sm, a, b, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
